// File: rtl/rsu_pkg.sv
// rsu_pkg: shared widths, command encodings and FSM states for the RSU serial initiator.
package rsu_pkg;

  localparam int unsigned RU_SR_WIDTH   = 41;
  localparam int unsigned RU_DATA_WIDTH = 39;

  typedef enum logic [1:0] {
    OP_READ     = 2'b00,
    OP_WRITE    = 2'b01,
    OP_RECONFIG = 2'b10,
    OP_RSVD     = 2'b11
  } rsu_op_e;

  localparam logic [1:0] RSU_SEL_CUR   = 2'b00;
  localparam logic [1:0] RSU_SEL_PREV1 = 2'b01;
  localparam logic [1:0] RSU_SEL_PREV2 = 2'b10;
  localparam logic [1:0] RSU_SEL_INPUT = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_SEL,
    CAPTURE,
    SHIFT_OUT,
    SHIFT_DATA,
    UPDATE,
    NCONFIG,
    DONE
  } rsu_state_e;

endpackage

// File: rtl/rsu_clk_gen.sv
// rsu_clk_gen: RU_CLK phase counter; CLK_DIV cycles low then CLK_DIV high while enabled.
module rsu_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic en,
  output logic ru_clk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int unsigned PW = $clog2(2 * CLK_DIV);

  logic [PW-1:0] phase;

  // rise_stb marks the last low cycle (RU_CLK goes high on its closing edge);
  // fall_stb marks the last high cycle, i.e. the end of a whole pulse.
  assign rise_stb = en && (phase == PW'(CLK_DIV - 1));
  assign fall_stb = en && (phase == PW'(2 * CLK_DIV - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      phase  <= '0;
      ru_clk <= 1'b0;
    end else if (!en || fall_stb) begin
      phase  <= '0;
      ru_clk <= 1'b0;
    end else begin
      phase <= phase + PW'(1);
      if (rise_stb) ru_clk <= 1'b1;
    end
  end

endmodule

// File: rtl/rsu_ctrl.sv
// rsu_ctrl: host-side initiator for the MAX10 RSU serial interface.
// Define RSU_WD_KICK_EN to add the wd_kick input and RU_nRSTIMER pulse output.
module rsu_ctrl
  import rsu_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned NCONFIG_CYCLES = 16
`ifdef RSU_WD_KICK_EN
  , parameter int unsigned WD_PULSE_CYCLES = 8
`endif
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [1:0]               cmd_sel,
  input  logic [RU_DATA_WIDTH-1:0] cmd_wdata,
  output logic                     rsp_valid,
  output logic [RU_DATA_WIDTH-1:0] rsp_rdata,
  output logic                     rsp_err,
  output logic                     RU_CLK,
  output logic                     RU_SHIFTnLD,
  output logic                     RU_CUPTnUPDT,
  output logic                     RU_DIN,
  input  logic                     RU_DOUT,
  output logic                     RU_nCONFIG
`ifdef RSU_WD_KICK_EN
  , input  logic                   wd_kick,
  output logic                     RU_nRSTIMER
`endif
);

  localparam int unsigned CW = $clog2(NCONFIG_CYCLES + 1);
  localparam logic [5:0]  BIT_LAST = 6'(RU_SR_WIDTH - 1);

  rsu_state_e               state, state_n;
  logic [RU_SR_WIDTH-1:0]   tx, tx_n, word;
  logic [RU_DATA_WIDTH-1:0] rx, rx_n, rdata_n;
  logic [5:0]               bit_cnt, bit_n;
  logic [CW-1:0]            cyc_cnt, cyc_n;
  logic din_n, shift_n, cupt_n, ncfg_n, rsp_valid_n, rsp_err_n;
  logic ru_en, rise_stb, fall_stb, last_bit;

  assign ru_en     = state inside {SHIFT_SEL, CAPTURE, SHIFT_OUT, SHIFT_DATA, UPDATE};
  assign last_bit  = (bit_cnt == BIT_LAST);
  assign cmd_ready = !RESET && ((state == IDLE) || (state == DONE));

  rsu_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .CLK      (CLK),
    .RESET    (RESET),
    .en       (ru_en),
    .ru_clk   (RU_CLK),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_comb begin
    // NOTE: every target gets a default before the case so no latch is inferred.
    state_n     = state;
    tx_n        = tx;
    rx_n        = rx;
    bit_n       = bit_cnt;
    cyc_n       = cyc_cnt;
    din_n       = RU_DIN;
    shift_n     = RU_SHIFTnLD;
    cupt_n      = RU_CUPTnUPDT;
    ncfg_n      = RU_nCONFIG;
    rsp_valid_n = 1'b0;
    rsp_err_n   = 1'b0;
    rdata_n     = '0;
    word        = '0;
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (cmd_valid) begin
          bit_n = '0;
          cyc_n = '0;
          case (rsu_op_e'(cmd_op))
            OP_READ: begin
              state_n = SHIFT_SEL;
              word    = {cmd_sel, {RU_DATA_WIDTH{1'b0}}};
            end
            OP_WRITE: begin
              state_n = SHIFT_DATA;
              word    = {2'b00, cmd_wdata};
            end
            OP_RECONFIG: begin
              state_n = NCONFIG;
              ncfg_n  = 1'b0;
            end
            default: begin
              state_n     = DONE;
              rsp_valid_n = 1'b1;
              rsp_err_n   = 1'b1;
            end
          endcase
          // Bit 0 is presented during the very first low phase at T+1.
          din_n = word[0];
          tx_n  = {1'b0, word[RU_SR_WIDTH-1:1]};
        end
      end
      SHIFT_SEL, SHIFT_DATA: begin
        if (fall_stb) begin
          if (last_bit) begin
            state_n = (state == SHIFT_SEL) ? CAPTURE : UPDATE;
            shift_n = 1'b0;
            cupt_n  = (state == SHIFT_SEL);
            din_n   = 1'b0;
          end else begin
            din_n = tx[0];
            tx_n  = {1'b0, tx[RU_SR_WIDTH-1:1]};
            bit_n = bit_cnt + 6'd1;
          end
        end
      end
      CAPTURE: begin
        if (fall_stb) begin
          state_n = SHIFT_OUT;
          shift_n = 1'b1;
          cupt_n  = 1'b1;
          bit_n   = '0;
        end
      end
      SHIFT_OUT: begin
        if (rise_stb && (bit_cnt < 6'(RU_DATA_WIDTH))) rx_n[bit_cnt] = RU_DOUT;
        if (fall_stb) begin
          if (last_bit) begin
            state_n     = DONE;
            rsp_valid_n = 1'b1;
            rdata_n     = rx;
          end else begin
            bit_n = bit_cnt + 6'd1;
          end
        end
      end
      UPDATE: begin
        if (fall_stb) begin
          state_n     = DONE;
          shift_n     = 1'b1;
          cupt_n      = 1'b1;
          rsp_valid_n = 1'b1;
        end
      end
      NCONFIG: begin
        if (cyc_cnt == CW'(NCONFIG_CYCLES - 1)) begin
          state_n     = DONE;
          ncfg_n      = 1'b1;
          rsp_valid_n = 1'b1;
        end else begin
          cyc_n = cyc_cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (RESET) begin
      state        <= IDLE;
      tx           <= '0;
      rx           <= '0;
      bit_cnt      <= '0;
      cyc_cnt      <= '0;
      RU_DIN       <= 1'b0;
      RU_SHIFTnLD  <= 1'b1;
      RU_CUPTnUPDT <= 1'b1;
      RU_nCONFIG   <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      state        <= state_n;
      tx           <= tx_n;
      rx           <= rx_n;
      bit_cnt      <= bit_n;
      cyc_cnt      <= cyc_n;
      RU_DIN       <= din_n;
      RU_SHIFTnLD  <= shift_n;
      RU_CUPTnUPDT <= cupt_n;
      RU_nCONFIG   <= ncfg_n;
      rsp_valid    <= rsp_valid_n;
      rsp_err      <= rsp_err_n;
      rsp_rdata    <= rdata_n;
    end
  end

`ifdef RSU_WD_KICK_EN
  localparam int unsigned WW = $clog2(WD_PULSE_CYCLES + 1);
  logic [WW-1:0] wd_cnt;

  // Independent of the command FSM; a kick always restarts the full pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wd_cnt      <= '0;
      RU_nRSTIMER <= 1'b1;
    end else if (wd_kick) begin
      wd_cnt      <= WW'(WD_PULSE_CYCLES - 1);
      RU_nRSTIMER <= 1'b0;
    end else if (!RU_nRSTIMER) begin
      if (wd_cnt == '0) RU_nRSTIMER <= 1'b1;
      else              wd_cnt      <= wd_cnt - WW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_rsu_ctrl.sv
// tb_rsu_ctrl: directed self-checking bench for rsu_ctrl with a behavioural RSU register model.
module tb_rsu_ctrl;
  import rsu_pkg::*;

  localparam logic [38:0] CUR_VAL   = 39'h0_2603_4A1B5;
  localparam logic [38:0] WR_VAL    = 39'h12_3456_3000;
  localparam int          READ_LAT  = 665;
  localparam int          WRITE_LAT = 337;
  localparam int          NCFG_LAT  = 17;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_err;
  logic [1:0]  cmd_op, cmd_sel;
  logic [38:0] cmd_wdata, rsp_rdata;
  logic        RU_CLK, RU_SHIFTnLD, RU_CUPTnUPDT, RU_DIN, RU_DOUT, RU_nCONFIG;
`ifdef RSU_WD_KICK_EN
  logic        wd_kick, RU_nRSTIMER;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_acc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  rsu_ctrl #(.CLK_DIV(4), .NCONFIG_CYCLES(16)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_sel      (cmd_sel),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .RU_CLK       (RU_CLK),
    .RU_SHIFTnLD  (RU_SHIFTnLD),
    .RU_CUPTnUPDT (RU_CUPTnUPDT),
    .RU_DIN       (RU_DIN),
    .RU_DOUT      (RU_DOUT),
    .RU_nCONFIG   (RU_nCONFIG)
`ifdef RSU_WD_KICK_EN
    , .wd_kick    (wd_kick),
    .RU_nRSTIMER  (RU_nRSTIMER)
`endif
  );

  // Behavioural RSU: 41-bit shift register, DIN into bit 40, DOUT from bit 0.
  logic [40:0] sr        = '0;
  logic [38:0] m_cur     = CUR_VAL;
  logic [38:0] m_prev1   = '0;
  logic [38:0] m_prev2   = '0;
  logic [38:0] m_input   = '0;
  logic        ru_clk_q  = 1'b0;
  int          run       = 0;
  int          run_at_ld = 0;
  int          rises     = 0;
  int          ncfg_low  = 0;
  int          rsp_cnt   = 0;
  int          nrst_low  = 0;

  assign RU_DOUT = sr[0];

  always @(posedge CLK) begin
    ru_clk_q <= RU_CLK;
    if (!RU_nCONFIG) ncfg_low <= ncfg_low + 1;
    if (rsp_valid)   rsp_cnt  <= rsp_cnt + 1;
`ifdef RSU_WD_KICK_EN
    if (!RU_nRSTIMER) nrst_low <= nrst_low + 1;
`endif
    if (cmd_valid && cmd_ready) begin
      run       <= 0;
      run_at_ld <= 0;
      rises     <= 0;
      ncfg_low  <= 0;
    end else if (RU_CLK && !ru_clk_q) begin
      rises <= rises + 1;
      if (RU_SHIFTnLD) begin
        sr  <= {RU_DIN, sr[40:1]};
        run <= run + 1;
      end else begin
        run_at_ld <= run;
        run       <= 0;
        if (RU_CUPTnUPDT) begin
          case (sr[40:39])
            RSU_SEL_CUR:   sr <= {sr[40:39], m_cur};
            RSU_SEL_PREV1: sr <= {sr[40:39], m_prev1};
            RSU_SEL_PREV2: sr <= {sr[40:39], m_prev2};
            default:       sr <= {sr[40:39], m_input};
          endcase
        end else begin
          m_input <= sr[38:0];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] sel, input logic [38:0] wd);
    @(negedge CLK);
    check("ready_before_cmd", 64'(cmd_ready), 64'd1);
    cmd_op    = op;
    cmd_sel   = sel;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    t_acc     = cyc;
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (rsp_valid) begin
        lat = cyc - t_acc;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ru_clk"}, 64'(RU_CLK), 64'd0);
    check({tag, "_shiftnld"}, 64'(RU_SHIFTnLD), 64'd1);
    check({tag, "_cuptnupdt"}, 64'(RU_CUPTnUPDT), 64'd1);
    check({tag, "_din"}, 64'(RU_DIN), 64'd0);
    check({tag, "_nconfig"}, 64'(RU_nCONFIG), 64'd1);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
`ifdef RSU_WD_KICK_EN
    check({tag, "_nrstimer"}, 64'(RU_nRSTIMER), 64'd1);
`endif
  endtask

  task automatic do_read(input logic [1:0] sel, input logic [38:0] exp, input string tag);
    int lat;
    issue(OP_READ, sel, '0);
    wait_rsp(lat);
    check({tag, "_lat"}, 64'(lat), 64'(READ_LAT));
    check({tag, "_rdata"}, 64'(rsp_rdata), 64'(exp));
    check({tag, "_err"}, 64'(rsp_err), 64'd0);
    check({tag, "_ready_done"}, 64'(cmd_ready), 64'd1);
    check({tag, "_sel_rises"}, 64'(run_at_ld), 64'd41);
    check({tag, "_out_rises"}, 64'(run), 64'd41);
    check({tag, "_clk_idle"}, 64'(RU_CLK), 64'd0);
  endtask

  initial begin
    int lat;
    int rsp_snap;
    RESET     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_sel   = '0;
    cmd_wdata = '0;
`ifdef RSU_WD_KICK_EN
    wd_kick   = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    check_reset_outputs("por");
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("ready_after_por", 64'(cmd_ready), 64'd1);

    do_read(RSU_SEL_CUR, CUR_VAL, "rd_cur");
    do_read(RSU_SEL_PREV1, 39'd0, "rd_prev1");
    do_read(RSU_SEL_PREV2, 39'd0, "rd_prev2");

    issue(OP_WRITE, 2'b00, WR_VAL);
    wait_rsp(lat);
    check("wr_lat", 64'(lat), 64'(WRITE_LAT));
    check("wr_err", 64'(rsp_err), 64'd0);
    check("wr_rdata", 64'(rsp_rdata), 64'd0);
    check("wr_shift_rises", 64'(run_at_ld), 64'd41);
    check("wr_total_rises", 64'(rises), 64'd42);
    check("wr_model_input", 64'(m_input), 64'(WR_VAL));
    check("wr_model_wd_en", 64'(m_input[12]), 64'd1);
    check("wr_model_img_sel", 64'(m_input[13]), 64'd1);
    do_read(RSU_SEL_INPUT, WR_VAL, "rd_input");

    issue(OP_RECONFIG, 2'b00, '0);
    wait_rsp(lat);
    check("rcfg_lat", 64'(lat), 64'(NCFG_LAT));
    check("rcfg_low_cycles", 64'(ncfg_low), 64'd16);
    check("rcfg_nconfig_done", 64'(RU_nCONFIG), 64'd1);
    check("rcfg_rises", 64'(rises), 64'd0);

    issue(OP_RSVD, 2'b00, '0);
    wait_rsp(lat);
    check("rsvd_lat", 64'(lat), 64'd1);
    check("rsvd_err", 64'(rsp_err), 64'd1);
    check("rsvd_rdata", 64'(rsp_rdata), 64'd0);
    check("rsvd_rises", 64'(rises), 64'd0);
    @(negedge CLK);
    check("rsvd_valid_pulse", 64'(rsp_valid), 64'd0);

    // Abort a read part-way through SHIFT_OUT (T+337..T+664).
    issue(OP_READ, RSU_SEL_CUR, '0);
    repeat (400) @(negedge CLK);
    rsp_snap = rsp_cnt;
    RESET = 1'b1;
    @(negedge CLK);
    check_reset_outputs("mid_rst");
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("ready_after_mid_rst", 64'(cmd_ready), 64'd1);
    repeat (300) @(negedge CLK);
    check("no_rsp_after_rst", 64'(rsp_cnt), 64'(rsp_snap));
    do_read(RSU_SEL_CUR, CUR_VAL, "rd_after_rst");

`ifdef RSU_WD_KICK_EN
    issue(OP_READ, RSU_SEL_CUR, '0);
    repeat (100) @(negedge CLK);
    wd_kick = 1'b1;
    @(negedge CLK);
    wd_kick = 1'b0;
    repeat (2) @(negedge CLK);
    wd_kick = 1'b1;
    @(negedge CLK);
    wd_kick = 1'b0;
    wait_rsp(lat);
    check("wd_read_lat", 64'(lat), 64'(READ_LAT));
    check("wd_read_rdata", 64'(rsp_rdata), 64'(CUR_VAL));
    check("wd_low_cycles", 64'(nrst_low), 64'd11);
    check("wd_nrstimer_idle", 64'(RU_nRSTIMER), 64'd1);
`endif

    @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
